// File: rtl/stage4_vmem_sequencer_pkg.sv
// Shared types for the rv32v memory stage: sequencer states and element widths.
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VEC   = 2'd1,
        VDONE = 2'd2
    } vmem_state_t;

    typedef enum logic [1:0] {
        EEW8     = 2'b00,
        EEW16    = 2'b01,
        EEW32    = 2'b10,
        EEW_RSVD = 2'b11
    } eew_t;

endpackage

// File: rtl/stage4_vmem_sequencer_if.sv
// Data-cache generic bus: one request channel with a busy back-pressure signal.
interface stage4_vmem_sequencer_if;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ren;
    logic        bus_wen;
    logic [3:0]  bus_byte_en;
    logic        bus_busy;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_ren, bus_wen, bus_byte_en,
        input  bus_busy, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_ren, bus_wen, bus_byte_en,
        output bus_busy, bus_rdata
    );

endinterface

// File: rtl/stage4_vmem_sequencer_lane_align.sv
// Byte-lane alignment for one element: byte enables, store lane shift,
// load extraction and the misalignment flag, all from (eew, offset).
module vmem_lane_align
    import rv32v_types_pkg::*;
(
    input  eew_t        eew,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out,
    output logic        misalign
);

    logic [31:0] rdata_shifted;

    // Lane selection per element width; reserved width always reports misalign.
    always_comb begin
        byte_en       = '0;
        misalign      = 1'b0;
        rdata_out     = '0;
        rdata_shifted = rdata_in >> {offset, 3'b000};
        wdata_out     = wdata_in << {offset, 3'b000};
        case (eew)
            EEW8: begin
                byte_en   = 4'b0001 << offset;
                rdata_out = {24'h0, rdata_shifted[7:0]};
            end
            EEW16: begin
                misalign  = offset[0];
                byte_en   = 4'b0011 << offset;
                rdata_out = {16'h0, rdata_shifted[15:0]};
            end
            EEW32: begin
                misalign  = (offset != 2'b00);
                byte_en   = 4'b1111;
                rdata_out = rdata_in;
            end
            default: begin
                misalign  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/stage4_vmem_sequencer.sv
// Memory-stage controller: shares the dcache port between scalar accesses and
// vector unit/strided accesses, issuing one bus request per vector element.
module stage4_vmem_sequencer
    import rv32v_types_pkg::*;
#(
    parameter int VL_W  = 6,
    parameter int IDX_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              s_ren,
    input  logic              s_wen,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_byte_en,
    output logic [31:0]       s_rdata,
    input  logic              v_req,
    input  logic              v_is_store,
    input  logic [31:0]       v_base,
    input  logic [31:0]       v_stride,
    input  logic [1:0]        v_eew,
    input  logic [VL_W-1:0]   v_vl,
    input  logic [31:0]       v_wdata,
    output logic [IDX_W-1:0]  v_idx,
    output logic [31:0]       v_rdata,
    output logic              v_rvalid,
    output logic              v_done,
    output logic              v_fault,
    stage4_vmem_sequencer_if.master bus,
    output logic              mem_stall
);

    vmem_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      addr_acc;
    logic             fault_q;

    eew_t        eew;
    logic        scalar_req;
    logic        in_idle;
    logic        in_vec;
    logic        accept;
    logic        vec_cmpl;
    logic        last_elem;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_misalign;

    assign eew        = eew_t'(v_eew);
    assign scalar_req = s_ren | s_wen;
    assign in_idle    = (state == IDLE);
    assign in_vec     = (state == VEC);
    assign accept     = in_idle & ~scalar_req & v_req;
    assign vec_cmpl   = in_vec & ~lane_misalign & ~bus.bus_busy;
    assign last_elem  = (VL_W'(idx) == v_vl - VL_W'(1));

    vmem_lane_align u_align (
        .eew       (eew),
        .offset    (addr_acc[1:0]),
        .wdata_in  (v_wdata),
        .rdata_in  (bus.bus_rdata),
        .byte_en   (lane_be),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata),
        .misalign  (lane_misalign)
    );

    // Sequencer FSM: accept, per-element walk, one-cycle completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            addr_acc <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= '0;
                        if (v_vl == '0 || eew == EEW_RSVD) begin
                            state   <= VDONE;
                            fault_q <= (eew == EEW_RSVD);
                        end else begin
                            state    <= VEC;
                            addr_acc <= v_base;
                        end
                    end
                end
                VEC: begin
                    if (lane_misalign) begin
                        fault_q <= 1'b1;
                        state   <= VDONE;
                    end else if (vec_cmpl) begin
                        idx      <= idx + IDX_W'(1);
                        addr_acc <= addr_acc + v_stride;
                        if (last_elem) begin
                            state <= VDONE;
                        end
                    end
                end
                VDONE: begin
                    state   <= IDLE;
                    fault_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus mux and status outputs; everything is forced quiet while RST is high.
    always_comb begin
        bus.bus_ren     = 1'b0;
        bus.bus_wen     = 1'b0;
        bus.bus_addr    = '0;
        bus.bus_wdata   = '0;
        bus.bus_byte_en = '0;
        s_rdata         = '0;
        v_idx           = '0;
        v_rdata         = '0;
        v_rvalid        = 1'b0;
        v_done          = 1'b0;
        v_fault         = 1'b0;
        mem_stall       = 1'b0;
        if (!RST) begin
            if (in_idle) begin
                bus.bus_ren     = s_ren;
                bus.bus_wen     = s_wen;
                bus.bus_addr    = {s_addr[31:2], 2'b00};
                bus.bus_wdata   = s_wdata;
                bus.bus_byte_en = s_byte_en;
            end else if (in_vec && !lane_misalign) begin
                bus.bus_ren     = ~v_is_store;
                bus.bus_wen     = v_is_store;
                bus.bus_addr    = {addr_acc[31:2], 2'b00};
                bus.bus_wdata   = lane_wdata;
                bus.bus_byte_en = lane_be;
            end
            s_rdata   = bus.bus_rdata;
            v_idx     = idx;
            v_rvalid  = vec_cmpl & ~v_is_store;
            v_rdata   = v_rvalid ? lane_rdata : '0;
            v_done    = (state == VDONE);
            v_fault   = (state == VDONE) & fault_q;
            mem_stall = (scalar_req & bus.bus_busy) | ~in_idle | (v_req & in_idle);
        end
    end

endmodule
